// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: word-organised data memory, lane steering, load extension and MEM/WB register.
// Optional MEM_DEBUG_PORT_EN adds a combinational debug read port (i_dbg_addr / o_dbg_data).
module mem_access_stage #(
  parameter int INST_SZ    = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [INST_SZ-1:0]    i_alu_result_M,
  input  logic [INST_SZ-1:0]    i_write_data_M,
  input  logic [INST_SZ-1:0]    i_branch_delay_slot_M,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_bhw_M,
  input  logic                  i_reg_write_M,
  input  logic                  i_mem_to_reg_M,
  input  logic                  i_bds_sel_M,
  input  logic [REG_ADDR_W-1:0] i_write_reg_M,
  output logic [INST_SZ-1:0]    o_alu_result_W,
  output logic [INST_SZ-1:0]    o_read_data_W,
  output logic [INST_SZ-1:0]    o_branch_delay_slot_W,
  output logic                  o_reg_write_W,
  output logic                  o_mem_to_reg_W,
  output logic                  o_bds_sel_W,
  output logic [REG_ADDR_W-1:0] o_write_reg_W,
  output logic                  o_misaligned_W
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [MEM_ADDR_W-1:0] i_dbg_addr,
  output logic [INST_SZ-1:0]    o_dbg_data
`endif
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;

  logic [INST_SZ-1:0]    r_mem [DEPTH];

  logic [MEM_ADDR_W-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [1:0]            w_size;
  logic                  w_unsigned;
  logic                  w_align_err;
  logic                  w_misaligned;
  logic                  w_store_en;
  logic [3:0]            w_be;
  logic [INST_SZ-1:0]    w_wdata;
  logic [INST_SZ-1:0]    w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [INST_SZ-1:0]    w_load_data;

  // Upper address bits are ignored, so the index wraps around the memory.
  assign w_idx      = i_alu_result_M[MEM_ADDR_W+1:2];
  assign w_lane     = i_alu_result_M[1:0];
  assign w_size     = i_bhw_M[1:0];
  assign w_unsigned = i_bhw_M[2];

  always_comb begin
    w_align_err = 1'b0;
    case (w_size)
      2'b00:   w_align_err = 1'b0;
      2'b01:   w_align_err = w_lane[0];
      default: w_align_err = |w_lane;
    endcase
  end

  assign w_misaligned = (i_mem_read_M | i_mem_write_M) & w_align_err;
  assign w_store_en   = i_mem_write_M & ~w_misaligned & ~i_stall & ~i_flush & ~i_reset;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_write_data_M;
    case (w_size)
      2'b00: begin
        w_be[w_lane] = 1'b1;
        w_wdata      = {4{i_write_data_M[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data_M[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Non-loads still return the raw word so the W-side value is always defined.
  always_comb begin
    w_load_data = w_word;
    if (i_mem_read_M) begin
      if (w_misaligned) begin
        w_load_data = '0;
      end else begin
        case (w_size)
          2'b00:   w_load_data = w_unsigned ? {{(INST_SZ-8){1'b0}}, w_byte}
                                            : {{(INST_SZ-8){w_byte[7]}}, w_byte};
          2'b01:   w_load_data = w_unsigned ? {{(INST_SZ-16){1'b0}}, w_half}
                                            : {{(INST_SZ-16){w_half[15]}}, w_half};
          default: w_load_data = w_word;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_result_W        <= '0;
      o_read_data_W         <= '0;
      o_branch_delay_slot_W <= '0;
      o_reg_write_W         <= 1'b0;
      o_mem_to_reg_W        <= 1'b0;
      o_bds_sel_W           <= 1'b0;
      o_write_reg_W         <= '0;
      o_misaligned_W        <= 1'b0;
    end else if (i_flush) begin
      o_alu_result_W        <= i_alu_result_M;
      o_read_data_W         <= w_load_data;
      o_branch_delay_slot_W <= i_branch_delay_slot_M;
      o_reg_write_W         <= 1'b0;
      o_mem_to_reg_W        <= 1'b0;
      o_bds_sel_W           <= 1'b0;
      o_write_reg_W         <= i_write_reg_M;
      o_misaligned_W        <= 1'b0;
    end else if (!i_stall) begin
      o_alu_result_W        <= i_alu_result_M;
      o_read_data_W         <= w_load_data;
      o_branch_delay_slot_W <= i_branch_delay_slot_M;
      o_reg_write_W         <= i_reg_write_M & ~(i_mem_read_M & w_misaligned);
      o_mem_to_reg_W        <= i_mem_to_reg_M;
      o_bds_sel_W           <= i_bds_sel_M;
      o_write_reg_W         <= i_write_reg_M;
      o_misaligned_W        <= w_misaligned;
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  assign o_dbg_data = r_mem[i_dbg_addr];
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, a stall-hold sequence and random traffic
// checked against a byte-level memory/pipeline-register model.
module tb_mem_access_stage;

  typedef struct {
    logic        rst, stall, flush, rd, wr;
    logic [2:0]  bhw;
    logic [31:0] addr, wdata;
    logic        regwr, m2r;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_rw, exp_m2r, exp_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, mem_read, mem_write, reg_write, mem_to_reg, bds_sel;
  logic [31:0] alu_result, write_data, bds;
  logic [2:0]  bhw;
  logic [4:0]  write_reg;
  logic [31:0] o_alu, o_rdata, o_bds;
  logic        o_rw, o_m2r, o_bsel, o_mis;
  logic [4:0]  o_wreg;
`ifdef MEM_DEBUG_PORT_EN
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  logic [31:0] e_alu, e_rd, e_bds;
  logic [4:0]  e_wreg;
  bit          e_rw, e_m2r, e_bsel, e_mis, e_rd_known;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
    .i_alu_result_M(alu_result), .i_write_data_M(write_data),
    .i_branch_delay_slot_M(bds), .i_mem_read_M(mem_read), .i_mem_write_M(mem_write),
    .i_bhw_M(bhw), .i_reg_write_M(reg_write), .i_mem_to_reg_M(mem_to_reg),
    .i_bds_sel_M(bds_sel), .i_write_reg_M(write_reg),
    .o_alu_result_W(o_alu), .o_read_data_W(o_rdata), .o_branch_delay_slot_W(o_bds),
    .o_reg_write_W(o_rw), .o_mem_to_reg_W(o_m2r), .o_bds_sel_W(o_bsel),
    .o_write_reg_W(o_wreg), .o_misaligned_W(o_mis)
`ifdef MEM_DEBUG_PORT_EN
    , .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst_i, stall_i, flush_i, rd_i, wr_i,
                              input logic [2:0] bhw_i, input logic [31:0] addr_i, wdata_i,
                              input logic regwr_i, m2r_i, chk_i, input logic [31:0] exp_rd_i,
                              input logic exp_rw_i, exp_m2r_i, exp_mis_i);
    vec_t v;
    v.rst = rst_i; v.stall = stall_i; v.flush = flush_i; v.rd = rd_i; v.wr = wr_i;
    v.bhw = bhw_i; v.addr = addr_i; v.wdata = wdata_i; v.regwr = regwr_i; v.m2r = m2r_i;
    v.chk_rd = chk_i; v.exp_rd = exp_rd_i;
    v.exp_rw = exp_rw_i; v.exp_m2r = exp_m2r_i; v.exp_mis = exp_mis_i;
    return v;
  endfunction

  // One M-stage cycle: drive, predict from the model, clock, compare every W output.
  task automatic apply(input vec_t v);
    int          lane, widx, nb;
    bit          mis, uns;
    longint      w, span, val;
    logic [31:0] ld;
    bit          ld_known;
    logic [4:0]  wreg_n;
    logic [31:0] bds_n;
    logic        bsel_n;

    bds_n  = $urandom;
    wreg_n = 5'($urandom);
    bsel_n = 1'($urandom);
    reset = v.rst; stall = v.stall; flush = v.flush;
    mem_read = v.rd; mem_write = v.wr; bhw = v.bhw;
    alu_result = v.addr; write_data = v.wdata;
    reg_write = v.regwr; mem_to_reg = v.m2r;
    bds = bds_n; write_reg = wreg_n; bds_sel = bsel_n;

    lane = int'(v.addr % 4);
    widx = int'((v.addr / 4) % 1024);
    nb   = (v.bhw[1:0] == 2'd0) ? 1 : (v.bhw[1:0] == 2'd1) ? 2 : 4;
    uns  = v.bhw[2];
    mis  = (v.rd || v.wr) && (lane % nb != 0);
    w    = longint'(m_mem[widx]);
    ld_known = m_known[widx];
    if (!v.rd) ld = m_mem[widx];
    else if (mis) begin ld = '0; ld_known = 1; end
    else if (nb == 4) ld = m_mem[widx];
    else begin
      span = longint'(1) << (8 * nb);
      val  = (w >> (8 * lane)) % span;
      if (!uns && val >= span / 2) val = val + (longint'(1) << 32) - span;
      ld = val[31:0];
    end

    @(posedge clk);
    #1;

    if (!v.rst && !v.flush && !v.stall && v.wr && !mis) begin
      for (int b = 0; b < nb; b++) begin
        w = (w & ~(longint'(255) << (8 * (lane + b))))
          | (((longint'(v.wdata) >> (8 * b)) & 255) << (8 * (lane + b)));
      end
      m_mem[widx] = w[31:0];
      if (nb == 4) m_known[widx] = 1;
    end

    if (v.rst) begin
      e_alu = '0; e_rd = '0; e_bds = '0; e_wreg = '0;
      e_rw = 0; e_m2r = 0; e_bsel = 0; e_mis = 0; e_rd_known = 1;
    end else if (v.flush || !v.stall) begin
      e_alu = v.addr; e_rd = ld; e_rd_known = ld_known; e_bds = bds_n; e_wreg = wreg_n;
      if (v.flush) begin
        e_rw = 0; e_m2r = 0; e_bsel = 0; e_mis = 0;
      end else begin
        e_rw = v.regwr && !(v.rd && mis); e_m2r = v.m2r; e_bsel = bsel_n; e_mis = mis;
      end
    end

    chk("alu_result_W", o_alu, e_alu);
    if (e_rd_known) chk("read_data_W", o_rdata, e_rd);
    chk("bds_W", o_bds, e_bds);
    chk("write_reg_W", 32'(o_wreg), 32'(e_wreg));
    chk("reg_write_W", 32'(o_rw), 32'(e_rw));
    chk("mem_to_reg_W", 32'(o_m2r), 32'(e_m2r));
    chk("bds_sel_W", 32'(o_bsel), 32'(e_bsel));
    chk("misaligned_W", 32'(o_mis), 32'(e_mis));
`ifdef MEM_DEBUG_PORT_EN
    dbg_addr = 10'($urandom_range(0, 63));
    #1;
    if (m_known[dbg_addr]) chk("dbg_data", dbg_data, m_mem[dbg_addr]);
`endif
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [31:0] held_rd;

  initial begin
    for (int i = 0; i < 1024; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    e_alu = '0; e_rd = '0; e_bds = '0; e_wreg = '0;
    e_rw = 0; e_m2r = 0; e_bsel = 0; e_mis = 0; e_rd_known = 0;
    reset = 1; stall = 0; flush = 0; mem_read = 0; mem_write = 0; bhw = 3'b011;
    alu_result = '0; write_data = '0; bds = '0; write_reg = '0;
    reg_write = 0; mem_to_reg = 0; bds_sel = 0;

    // Reset, then bring the test window (words 0..63) to a known value.
    apply(mk(1,0,0, 0,0, 3'b011, 32'h0, 32'h0, 1,1, 1, 32'h0, 0,0,0));
    apply(mk(1,0,0, 1,1, 3'b011, 32'h10, 32'h5, 1,1, 1, 32'h0, 0,0,0));
    for (int i = 0; i < 64; i++)
      apply(mk(0,0,0, 0,1, 3'b011, 32'(i * 4), 32'h0, 0,0, 0, 32'h0, 0,0,0));

    //           rst stl fl rd wr bhw     addr         wdata        rw m2r chk exp_rd      e_rw e_m2r e_mis
    tbl.push_back(mk(0,0,0, 0,1, 3'b011, 32'h10, 32'hDEADBEEF, 0,0, 0, 32'h0,        0,0,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h10, 32'h0,        1,1, 1, 32'hDEADBEEF, 1,1,0));
    tbl.push_back(mk(0,0,0, 0,1, 3'b000, 32'h13, 32'h00000080, 0,0, 0, 32'h0,        0,0,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b000, 32'h13, 32'h0,        1,1, 1, 32'hFFFFFF80, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b100, 32'h13, 32'h0,        1,1, 1, 32'h00000080, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h10, 32'h0,        1,1, 1, 32'h80ADBEEF, 1,1,0));
    tbl.push_back(mk(0,0,0, 0,1, 3'b001, 32'h22, 32'h00008001, 0,0, 0, 32'h0,        0,0,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b001, 32'h22, 32'h0,        1,1, 1, 32'hFFFF8001, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b101, 32'h22, 32'h0,        1,1, 1, 32'h00008001, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b001, 32'h21, 32'h0,        1,1, 1, 32'h0,        0,1,1));
    tbl.push_back(mk(0,1,0, 0,1, 3'b011, 32'h30, 32'h12345678, 0,0, 1, 32'h0,        0,1,1));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h30, 32'h0,        1,1, 1, 32'h0,        1,1,0));
    tbl.push_back(mk(0,1,1, 0,1, 3'b011, 32'h30, 32'hAAAA5555, 1,0, 1, 32'h0,        0,0,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h30, 32'h0,        1,1, 1, 32'h0,        1,1,0));
    tbl.push_back(mk(0,0,0, 0,1, 3'b011, 32'h40, 32'hCAFEF00D, 0,0, 0, 32'h0,        0,0,0));
    tbl.push_back(mk(1,0,0, 0,1, 3'b011, 32'h40, 32'h11111111, 1,1, 1, 32'h0,        0,0,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h40, 32'h0,        1,1, 1, 32'hCAFEF00D, 1,1,0));
    tbl.push_back(mk(0,0,0, 0,1, 3'b011, 32'h41, 32'hFFFFFFFF, 0,0, 0, 32'h0,        0,0,1));
    tbl.push_back(mk(0,0,0, 1,0, 3'b010, 32'h40, 32'h0,        1,1, 1, 32'hCAFEF00D, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,0, 3'b011, 32'h1042, 32'h0,      1,1, 1, 32'h0,        0,1,1));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d read_data", i), o_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d reg_write", i), 32'(o_rw), 32'(tbl[i].exp_rw));
      chk($sformatf("tbl%0d mem_to_reg", i), 32'(o_m2r), 32'(tbl[i].exp_m2r));
      chk($sformatf("tbl%0d misaligned", i), 32'(o_mis), 32'(tbl[i].exp_mis));
    end

    // Multi-cycle stall: W holds the load result while stores issued under stall are dropped.
    apply(mk(0,0,0, 1,0, 3'b011, 32'h10, 32'h0, 1,1, 1, 32'h0, 1,1,0));
    chk("seq load", o_rdata, 32'h80ADBEEF);
    held_rd = o_rdata;
    for (int k = 0; k < 3; k++) begin
      apply(mk(0,1,0, 0,1, 3'(k), 32'h10 + 32'(k), 32'hFFFFFFFF, 0,0, 0, 32'h0, 0,0,0));
      chk("seq stall hold rdata", o_rdata, 32'h80ADBEEF);
      chk("seq stall hold reg_write", 32'(o_rw), 32'd1);
      chk("seq stall hold alu", o_alu, 32'h10);
    end
    apply(mk(0,0,0, 1,0, 3'b011, 32'h10, 32'h0, 1,1, 1, 32'h0, 1,1,0));
    chk("seq after stall", o_rdata, held_rd);

    // Random traffic over a small window; high address bits exercise the wrap-around.
    for (int n = 0; n < 2000; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      v = mk(($urandom % 60) == 0, ($urandom % 6) == 0, ($urandom % 9) == 0,
             op == 0 || op == 3, op == 1 || op == 3, 3'($urandom),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom,
             1'($urandom), 1'($urandom), 0, 32'h0, 0,0,0);
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
